tlc_multi_ctrl: RTL and testbench
=================================

Name: tlc_multi_ctrl

Overview:
- Parametrised, sensor-actuated traffic light controller for NUM_DIR approaches. It replaces the fixed two-approach A/B controller.
- Adds the following over the two-approach controller: per-approach request latching, round-robin service, min/max green with gap-out, yellow and all-red clearance, and a time-base enable.
- Sits between the intersection sensor inputs and the lamp drivers.

Parameters:
- NUM_DIR, 4, number of approaches (>=2)
- CNT_W, 8, phase timer width
- T_GREEN_MIN, 4, minimum green duration in ticks (>=1)
- T_GREEN_MAX, 8, maximum green duration in ticks when other demand exists (>=T_GREEN_MIN)
- T_YELLOW, 2, yellow (orange) duration in ticks (>=1)
- T_ALLRED, 1, all-red clearance duration in ticks (>=1)
- All durations must be < 2**CNT_W.

Ports:
- clk, in, 1, system clock, rising edge
- res, in, 1, synchronous active-low reset
- tick, in, 1, time-base enable; timers advance only on cycles with tick=1
- sns, in, NUM_DIR, vehicle presence per approach, level-sensitive
- grn, out, NUM_DIR, green lamp per approach
- org, out, NUM_DIR, orange/yellow lamp per approach
- red, out, NUM_DIR, red lamp per approach
- dir, out, clog2(NUM_DIR), currently served approach
- req, out, NUM_DIR, pending latched requests (debug/status)

Behaviour:
- Reset: one clk edge with res=0 gives state=ALLRED, ctr=0, dir=0, req=0, grn=0, org=0, red=all ones. Reset wins over every other event, including mid-phase.
- Outputs are Moore, decoded from registered state and dir. There is no combinational path from sns or tick to any output.
- Lamp decode:
  - grn = onehot(dir) in GREEN, else 0.
  - org = onehot(dir) in YELLOW, else 0.
  - red = ~(grn|org).
- Invariant: at most one bit of grn|org is set at any time.
- States: ALLRED -> GREEN -> YELLOW -> ALLRED.
- Timer ctr:
  - Cleared on every state entry; changes only on tick=1 cycles.
  - A state of duration D occupies exactly D tick pulses: on tick, if ctr==D-1 the state transitions, else ctr++.
  - In GREEN, ctr saturates at T_GREEN_MAX-1.
- Request latch:
  - req[i] sets on any cycle with sns[i]=1, unless state==GREEN and dir==i.
  - req[i] clears on the edge entering GREEN with dir==i. Clear wins over a simultaneous set.
- GREEN exit, evaluated only on tick cycles. Let other = |(req & ~onehot(dir)).
  - Gap-out: ctr>=T_GREEN_MIN-1 and other and sns[dir]==0 -> YELLOW.
  - Max-out: ctr==T_GREEN_MAX-1 and other -> YELLOW, regardless of sns[dir].
  - No other demand: rest in GREEN indefinitely.
- YELLOW: T_YELLOW ticks, then ALLRED.
- ALLRED: T_ALLRED ticks, then GREEN.
  - Next dir = first i with req[i]=1, searching dir+1, dir+2, ... modulo NUM_DIR (round robin). The search includes dir itself last.
  - If req==0, dir is unchanged (after reset this gives approach 0).
- tick held at 1 makes all durations count in clk cycles.
- tick=0 freezes ctr and state. Requests still latch while frozen.

Decomposition:
- Package tlc_pkg:
  - state enum {ALLRED, GREEN, YELLOW}
  - DIR_W = clog2(NUM_DIR) helper function
  - onehot decode function
- Sub-module tlc_rr_arbiter (combinational): inputs req, dir; outputs next_dir, any_other.
- Request latch, timer and FSM stay in tlc_multi_ctrl.
- Elaboration-time assertions enforce the parameter ranges.

Test Plan:
Defaults: NUM_DIR=4, T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALLRED=1, tick=1 unless stated.
1. Reset and rest:
   - Stimulus: res=0 for 2 cycles, then res=1, sns=0.
   - Response: red=4'b1111 and grn=0 during reset; after 1 cycle grn=4'b0001, dir=0; grn holds 0001 for 50+ cycles.
2. Gap-out:
   - Stimulus: dir0 green, sns[0]=0; pulse sns[2] for 1 cycle at green entry.
   - Response: grn=0001 for exactly 4 cycles, org=0001 for 2, red=1111 for 1, then grn=0100 and req[2]=0.
3. Max-out:
   - Stimulus: sns[0] held 1; pulse sns[1] at green entry.
   - Response: grn=0001 for exactly 8 cycles, then yellow, all-red, grn=0010.
4. Round-robin:
   - Stimulus: dir=1 green; req[0] and req[3] set.
   - Response: service order 3 then 0; each req bit clears on its own green entry.
5. Tick gating:
   - Stimulus: tick=1 every 3rd cycle.
   - Response: yellow lasts 6 clk cycles, all-red 3; no state change on tick=0 cycles.
6. Reset mid-operation:
   - Stimulus: res=0 for 1 cycle during YELLOW of dir 2.
   - Response: next cycle org=0, red=1111, dir=0, req=0; grn|org never shows more than one bit set throughout.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and helpers for the multi-approach traffic light controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    // Widest approach vector the one-hot helper can decode.
    localparam int MAX_DIR = 32;

    function automatic int dir_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_DIR-1:0] onehot(input int unsigned idx);
        return MAX_DIR'(1) << idx;
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Round-robin selection of the next approach to serve, starting after the current one.
module tlc_rr_arbiter
    import tlc_pkg::*;
#(
    parameter  int NUM_DIR = 4,
    localparam int DIR_W   = dir_w(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [DIR_W-1:0]   dir,
    output logic [DIR_W-1:0]   next_dir,
    output logic               any_other
);

    logic               found_s;
    int                 idx_s;
    logic [NUM_DIR-1:0] cur_oh_s;

    // Scan dir+1 .. dir+NUM_DIR (current approach last) for the first pending request.
    always_comb begin
        next_dir = dir;
        found_s  = 1'b0;
        idx_s    = 0;
        for (int k = 1; k <= NUM_DIR; k++) begin
            idx_s = (int'(dir) + k) % NUM_DIR;
            if (!found_s && req[idx_s]) begin
                next_dir = DIR_W'(idx_s);
                found_s  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Demand from any approach other than the one being served.
    always_comb begin
        cur_oh_s  = NUM_DIR'(onehot(32'(dir)));
        any_other = |(req & ~cur_oh_s);
    end

endmodule

// File: rtl/tlc_multi_ctrl.sv
// Sensor-actuated traffic light controller: request latch, phase timer and
// ALLRED -> GREEN -> YELLOW FSM with registered lamp outputs.
module tlc_multi_ctrl
    import tlc_pkg::*;
#(
    parameter  int NUM_DIR     = 4,
    parameter  int CNT_W       = 8,
    parameter  int T_GREEN_MIN = 4,
    parameter  int T_GREEN_MAX = 8,
    parameter  int T_YELLOW    = 2,
    parameter  int T_ALLRED    = 1,
    localparam int DIR_W       = dir_w(NUM_DIR)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               tick,
    input  logic [NUM_DIR-1:0] sns,
    output logic [NUM_DIR-1:0] grn,
    output logic [NUM_DIR-1:0] org,
    output logic [NUM_DIR-1:0] red,
    output logic [DIR_W-1:0]   dir,
    output logic [NUM_DIR-1:0] req
);

    localparam logic [CNT_W-1:0] GMIN_L = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_L = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_L  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_L   = CNT_W'(T_ALLRED - 1);

    if (NUM_DIR < 2 || NUM_DIR > MAX_DIR) begin : g_bad_num_dir
        $error("tlc_multi_ctrl: NUM_DIR out of range");
    end
    if (T_GREEN_MIN < 1 || T_GREEN_MAX < T_GREEN_MIN || T_YELLOW < 1 || T_ALLRED < 1) begin : g_bad_dur
        $error("tlc_multi_ctrl: phase duration out of range");
    end
    if (CNT_W < 31 && (T_GREEN_MAX >= (1 << CNT_W) || T_YELLOW >= (1 << CNT_W) ||
                       T_ALLRED >= (1 << CNT_W))) begin : g_bad_cnt_w
        $error("tlc_multi_ctrl: CNT_W too narrow for durations");
    end

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   ctr_r, ctr_nxt_s;
    logic [DIR_W-1:0]   dir_r, dir_nxt_s, rr_dir_s;
    logic [NUM_DIR-1:0] req_r, req_nxt_s;
    logic [NUM_DIR-1:0] cur_oh_s, nxt_oh_s, grn_nxt_s, org_nxt_s;
    logic               any_other_s;

    tlc_rr_arbiter #(.NUM_DIR(NUM_DIR)) u_arb (
        .req       (req_r),
        .dir       (dir_r),
        .next_dir  (rr_dir_s),
        .any_other (any_other_s)
    );

    // Phase sequencing and timer; everything is frozen on non-tick cycles.
    always_comb begin
        state_nxt_s = state_r;
        ctr_nxt_s   = ctr_r;
        dir_nxt_s   = dir_r;
        case (state_r)
            ALLRED: begin
                if (tick && ctr_r == AR_L) begin
                    state_nxt_s = GREEN;
                    ctr_nxt_s   = '0;
                    dir_nxt_s   = rr_dir_s;
                end else if (tick) begin
                    ctr_nxt_s = ctr_r + CNT_W'(1);
                end else begin
                    ctr_nxt_s = ctr_r;
                end
            end
            GREEN: begin
                // Gap-out after min green, or forced max-out; only when someone else waits.
                if (tick && any_other_s && ((ctr_r >= GMIN_L && !sns[dir_r]) || ctr_r == GMAX_L)) begin
                    state_nxt_s = YELLOW;
                    ctr_nxt_s   = '0;
                end else if (tick && ctr_r != GMAX_L) begin
                    ctr_nxt_s = ctr_r + CNT_W'(1);
                end else begin
                    ctr_nxt_s = ctr_r;
                end
            end
            YELLOW: begin
                if (tick && ctr_r == YEL_L) begin
                    state_nxt_s = ALLRED;
                    ctr_nxt_s   = '0;
                end else if (tick) begin
                    ctr_nxt_s = ctr_r + CNT_W'(1);
                end else begin
                    ctr_nxt_s = ctr_r;
                end
            end
            default: begin
                state_nxt_s = ALLRED;
                ctr_nxt_s   = '0;
            end
        endcase
    end

    // Request latch and next-cycle lamp decode; green entry clears its own request.
    always_comb begin
        cur_oh_s  = NUM_DIR'(onehot(32'(dir_r)));
        nxt_oh_s  = NUM_DIR'(onehot(32'(dir_nxt_s)));
        req_nxt_s = req_r | (sns & ~((state_r == GREEN) ? cur_oh_s : '0));
        if (state_r != GREEN && state_nxt_s == GREEN) begin
            req_nxt_s = req_nxt_s & ~nxt_oh_s;
        end else begin
            req_nxt_s = req_nxt_s;
        end
        grn_nxt_s = (state_nxt_s == GREEN)  ? nxt_oh_s : '0;
        org_nxt_s = (state_nxt_s == YELLOW) ? nxt_oh_s : '0;
    end

    // State, timer, request and lamp registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_r <= ALLRED;
            ctr_r   <= '0;
            dir_r   <= '0;
            req_r   <= '0;
            grn     <= '0;
            org     <= '0;
            red     <= '1;
        end else begin
            state_r <= state_nxt_s;
            ctr_r   <= ctr_nxt_s;
            dir_r   <= dir_nxt_s;
            req_r   <= req_nxt_s;
            grn     <= grn_nxt_s;
            org     <= org_nxt_s;
            red     <= ~(grn_nxt_s | org_nxt_s);
        end
    end

    assign dir = dir_r;
    assign req = req_r;

endmodule

// File: tb/tb_tlc_multi_ctrl.sv
// Directed self-checking bench for tlc_multi_ctrl with default timing parameters.
module tb_tlc_multi_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       tick;
    logic [3:0] sns;
    logic [3:0] grn, org, red, req;
    logic [1:0] dir;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   inv_err  = 0;
    logic gate     = 1'b0;
    int   ph       = 0;

    always #5 clk = ~clk;

    tlc_multi_ctrl #(
        .NUM_DIR(4), .CNT_W(8), .T_GREEN_MIN(4), .T_GREEN_MAX(8), .T_YELLOW(2), .T_ALLRED(1)
    ) dut (
        .clk(clk), .res(res), .tick(tick), .sns(sns),
        .grn(grn), .org(org), .red(red), .dir(dir), .req(req)
    );

    // Lamp invariant watched continuously outside reset
    always @(negedge clk) begin
        if (res === 1'b1) begin
            if ($countones(grn | org) > 1 || red !== ~(grn | org)) inv_err++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (gate) begin
            ph   = (ph + 1) % 3;
            tick = (ph == 2);
        end else begin
            tick = 1'b1;
        end
    endtask

    // Count consecutive sampled cycles where the selected lamp vector equals pat
    task automatic run_len(input int sel, input logic [3:0] pat, output int n);
        logic [3:0] cur;
        n   = 0;
        cur = (sel == 0) ? grn : (sel == 1) ? org : red;
        while (cur == pat && n < 100) begin
            n++;
            step();
            cur = (sel == 0) ? grn : (sel == 1) ? org : red;
        end
    endtask

    task automatic do_reset();
        res = 1'b0; sns = 4'b0000; tick = 1'b1; gate = 1'b0;
        step();
        res = 1'b1;
        step();
    endtask

    task automatic test_reset();
        int bad;
        res = 1'b0; sns = 4'b0000; tick = 1'b1; gate = 1'b0;
        step(); step();
        n_checks++; if (red !== 4'b1111) $display("FAIL rst_red: got %b want %b", red, 4'b1111); else n_pass++;
        n_checks++; if (grn !== 4'b0000) $display("FAIL rst_grn: got %b want %b", grn, 4'b0000); else n_pass++;
        n_checks++; if (org !== 4'b0000) $display("FAIL rst_org: got %b want %b", org, 4'b0000); else n_pass++;
        n_checks++; if (dir !== 2'd0) $display("FAIL rst_dir: got %0d want %0d", dir, 0); else n_pass++;
        n_checks++; if (req !== 4'b0000) $display("FAIL rst_req: got %b want %b", req, 4'b0000); else n_pass++;
        res = 1'b1;
        step();
        n_checks++; if (grn !== 4'b0001) $display("FAIL rest_grn: got %b want %b", grn, 4'b0001); else n_pass++;
        n_checks++; if (dir !== 2'd0) $display("FAIL rest_dir: got %0d want %0d", dir, 0); else n_pass++;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (grn !== 4'b0001) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL rest_hold: got %0d bad cycles want %0d", bad, 0); else n_pass++;
    endtask

    task automatic test_gap_out();
        int n;
        do_reset();
        sns = 4'b0100;
        step();
        sns = 4'b0000;
        n_checks++; if (req !== 4'b0100) $display("FAIL gap_req_set: got %b want %b", req, 4'b0100); else n_pass++;
        run_len(0, 4'b0001, n);
        n_checks++; if (n + 1 != 4) $display("FAIL gap_green_len: got %0d want %0d", n + 1, 4); else n_pass++;
        run_len(1, 4'b0001, n);
        n_checks++; if (n != 2) $display("FAIL gap_yellow_len: got %0d want %0d", n, 2); else n_pass++;
        run_len(2, 4'b1111, n);
        n_checks++; if (n != 1) $display("FAIL gap_allred_len: got %0d want %0d", n, 1); else n_pass++;
        n_checks++; if (grn !== 4'b0100 || dir !== 2'd2) $display("FAIL gap_next: got grn=%b dir=%0d want grn=%b dir=%0d", grn, dir, 4'b0100, 2); else n_pass++;
        n_checks++; if (req !== 4'b0000) $display("FAIL gap_req_clr: got %b want %b", req, 4'b0000); else n_pass++;
    endtask

    task automatic test_max_out();
        int n;
        do_reset();
        sns = 4'b0011;
        step();
        sns = 4'b0001;
        run_len(0, 4'b0001, n);
        sns = 4'b0000;
        n_checks++; if (n + 1 != 8) $display("FAIL max_green_len: got %0d want %0d", n + 1, 8); else n_pass++;
        run_len(1, 4'b0001, n);
        n_checks++; if (n != 2) $display("FAIL max_yellow_len: got %0d want %0d", n, 2); else n_pass++;
        run_len(2, 4'b1111, n);
        n_checks++; if (n != 1) $display("FAIL max_allred_len: got %0d want %0d", n, 1); else n_pass++;
        n_checks++; if (grn !== 4'b0010) $display("FAIL max_next_grn: got %b want %b", grn, 4'b0010); else n_pass++;
        n_checks++; if (req !== 4'b0000) $display("FAIL max_req: got %b want %b", req, 4'b0000); else n_pass++;
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        sns = 4'b0010;
        step();
        sns = 4'b0000;
        run_len(0, 4'b0001, n);
        run_len(1, 4'b0001, n);
        run_len(2, 4'b1111, n);
        n_checks++; if (grn !== 4'b0010 || dir !== 2'd1) $display("FAIL rr_start: got grn=%b dir=%0d want grn=%b dir=%0d", grn, dir, 4'b0010, 1); else n_pass++;
        sns = 4'b1001;
        step();
        sns = 4'b0000;
        n_checks++; if (req !== 4'b1001) $display("FAIL rr_req_set: got %b want %b", req, 4'b1001); else n_pass++;
        run_len(0, 4'b0010, n);
        run_len(1, 4'b0010, n);
        run_len(2, 4'b1111, n);
        n_checks++; if (grn !== 4'b1000 || dir !== 2'd3) $display("FAIL rr_first: got grn=%b dir=%0d want grn=%b dir=%0d", grn, dir, 4'b1000, 3); else n_pass++;
        n_checks++; if (req !== 4'b0001) $display("FAIL rr_req3_clr: got %b want %b", req, 4'b0001); else n_pass++;
        run_len(0, 4'b1000, n);
        n_checks++; if (n != 4) $display("FAIL rr_green3_len: got %0d want %0d", n, 4); else n_pass++;
        run_len(1, 4'b1000, n);
        run_len(2, 4'b1111, n);
        n_checks++; if (grn !== 4'b0001 || dir !== 2'd0) $display("FAIL rr_second: got grn=%b dir=%0d want grn=%b dir=%0d", grn, dir, 4'b0001, 0); else n_pass++;
        n_checks++; if (req !== 4'b0000) $display("FAIL rr_req0_clr: got %b want %b", req, 4'b0000); else n_pass++;
    endtask

    task automatic test_tick_gating();
        int n;
        do_reset();
        gate = 1'b1; ph = 0; tick = 1'b0;
        sns = 4'b0100;
        step();
        sns = 4'b0000;
        run_len(0, 4'b0001, n);
        n_checks++; if (n + 1 != 12) $display("FAIL tick_green_len: got %0d want %0d", n + 1, 12); else n_pass++;
        run_len(1, 4'b0001, n);
        n_checks++; if (n != 6) $display("FAIL tick_yellow_len: got %0d want %0d", n, 6); else n_pass++;
        run_len(2, 4'b1111, n);
        n_checks++; if (n != 3) $display("FAIL tick_allred_len: got %0d want %0d", n, 3); else n_pass++;
        n_checks++; if (grn !== 4'b0100) $display("FAIL tick_next_grn: got %b want %b", grn, 4'b0100); else n_pass++;
        gate = 1'b0; tick = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        sns = 4'b0100;
        step();
        sns = 4'b0000;
        run_len(0, 4'b0001, n);
        run_len(1, 4'b0001, n);
        run_len(2, 4'b1111, n);
        sns = 4'b0001;
        step();
        sns = 4'b0000;
        run_len(0, 4'b0100, n);
        n_checks++; if (org !== 4'b0100) $display("FAIL mid_in_yellow: got %b want %b", org, 4'b0100); else n_pass++;
        n_checks++; if (req !== 4'b0001) $display("FAIL mid_req_pend: got %b want %b", req, 4'b0001); else n_pass++;
        res = 1'b0;
        step();
        n_checks++; if (org !== 4'b0000) $display("FAIL mid_org: got %b want %b", org, 4'b0000); else n_pass++;
        n_checks++; if (red !== 4'b1111) $display("FAIL mid_red: got %b want %b", red, 4'b1111); else n_pass++;
        n_checks++; if (grn !== 4'b0000) $display("FAIL mid_grn: got %b want %b", grn, 4'b0000); else n_pass++;
        n_checks++; if (dir !== 2'd0) $display("FAIL mid_dir: got %0d want %0d", dir, 0); else n_pass++;
        n_checks++; if (req !== 4'b0000) $display("FAIL mid_req: got %b want %b", req, 4'b0000); else n_pass++;
        res = 1'b1;
        step();
    endtask

    task automatic test_invariant();
        n_checks++; if (inv_err != 0) $display("FAIL lamp_invariant: got %0d violations want %0d", inv_err, 0); else n_pass++;
    endtask

    initial begin
        res = 1'b0; tick = 1'b1; sns = 4'b0000;
        test_reset();
        test_gap_out();
        test_max_out();
        test_round_robin();
        test_tick_gating();
        test_reset_mid();
        test_invariant();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
